// File: rtl/flash_spi_reader.sv
// SPI NOR read engine for the boot loader: one 03h read of a 32-bit word per request,
// returned little-endian with a one-cycle ack and a guaranteed chip-select gap afterwards.
module flash_spi_reader #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        i_flash_cycle,
  input  logic [31:0] i_flash_addr,
  output logic        o_flash_ack,
  output logic [31:0] o_flash_data,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [1:0] {IDLE, SHIFT, ACK, GAP} state_t;

  state_t      state;
  state_t      next_state;
  logic        armed;
  logic [7:0]  div_cnt;
  logic [7:0]  gap_cnt;
  logic [6:0]  bit_cnt;
  logic [63:0] tx_word;
  logic [31:0] rx_word;
  logic [63:0] start_word;
  logic        start;
  logic        toggle;
  logic        last_fall;
  logic        gap_done;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{i_flash_addr[31:24], i_flash_addr[1:0]};

  always_comb begin
    start_word = {8'h03, i_flash_addr[23:2], 2'b00, 32'h0};
    start      = (state == IDLE) && i_flash_cycle && armed;
    toggle     = (state == SHIFT) && (div_cnt == 8'(CLK_DIV - 1));
    last_fall  = toggle && spi_sck && (bit_cnt == 7'd63);
    gap_done   = (state == GAP) && (gap_cnt >= 8'(CS_GAP - 1));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start)     next_state = SHIFT;
      SHIFT:   if (last_fall) next_state = ACK;
      ACK:                    next_state = GAP;
      GAP:     if (gap_done)  next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  // The ACK cycle counts as the first cycle of the chip-select gap.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      armed        <= 1'b1;
      div_cnt      <= 8'h0;
      gap_cnt      <= 8'h0;
      bit_cnt      <= 7'h0;
      tx_word      <= 64'h0;
      rx_word      <= 32'h0;
      spi_cs_n     <= 1'b1;
      spi_sck      <= 1'b0;
      spi_mosi     <= 1'b0;
      o_flash_ack  <= 1'b0;
      o_flash_data <= 32'h0;
    end else begin
      if ((state == IDLE || state == GAP) && !i_flash_cycle)
        armed <= 1'b1;
      case (state)
        IDLE: begin
          gap_cnt <= 8'h0;
          if (start) begin
            armed    <= 1'b0;
            tx_word  <= start_word;
            div_cnt  <= 8'h0;
            bit_cnt  <= 7'h0;
            spi_cs_n <= 1'b0;
            spi_sck  <= 1'b0;
            spi_mosi <= start_word[63];
          end
        end
        SHIFT: begin
          if (toggle) begin
            div_cnt <= 8'h0;
            spi_sck <= ~spi_sck;
            if (!spi_sck) begin
              rx_word <= {rx_word[30:0], spi_miso};
            end else begin
              tx_word  <= {tx_word[62:0], 1'b0};
              spi_mosi <= tx_word[62];
              bit_cnt  <= bit_cnt + 7'd1;
              if (last_fall) begin
                spi_cs_n     <= 1'b1;
                spi_mosi     <= 1'b0;
                o_flash_ack  <= 1'b1;
                o_flash_data <= {rx_word[7:0], rx_word[15:8], rx_word[23:16], rx_word[31:24]};
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        ACK: begin
          o_flash_ack <= 1'b0;
          gap_cnt     <= 8'd1;
        end
        GAP: begin
          if (!gap_done) gap_cnt <= gap_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_spi_reader.sv
// Directed bench: two readers (CLK_DIV=2 and CLK_DIV=1) against a small mode-0 flash model.
module tb_flash_spi_reader;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        cyc0 = 1'b0, cyc1 = 1'b0;
  logic [31:0] addr = 32'h0;
  logic        ack0, ack1, cs0, cs1, sck0, sck1, mosi0, mosi1;
  logic        miso0 = 1'b0, miso1 = 1'b0;
  logic [31:0] data0, data1;
  logic [31:0] resp0 = 32'h0, resp1 = 32'h0;

  int compareCnt = 0;
  int failCnt    = 0;

  always #5 sys_clk = ~sys_clk;

  flash_spi_reader #(.CLK_DIV(2), .CS_GAP(4)) dut0 (
    .sys_clk(sys_clk), .sys_rst_n(rst_n), .i_flash_cycle(cyc0), .i_flash_addr(addr),
    .o_flash_ack(ack0), .o_flash_data(data0), .spi_cs_n(cs0), .spi_sck(sck0),
    .spi_mosi(mosi0), .spi_miso(miso0));

  flash_spi_reader #(.CLK_DIV(1), .CS_GAP(4)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(rst_n), .i_flash_cycle(cyc1), .i_flash_addr(addr),
    .o_flash_ack(ack1), .o_flash_data(data1), .spi_cs_n(cs1), .spi_sck(sck1),
    .spi_mosi(mosi1), .spi_miso(miso1));

  // Flash model: returns 32 zero bits during command/address, then resp bytes MSB first.
  function automatic logic modelBit(input logic [31:0] r, input int k);
    if (k >= 32 && k < 64) return r[63-k];
    return 1'b0;
  endfunction

  int          rise0 = 0, rise1 = 0;
  logic [63:0] log0 = '0, log1 = '0;
  logic        prevCs0 = 1'b1, prevSck0 = 1'b0, prevCs1 = 1'b1, prevSck1 = 1'b0;

  always @(cs0, sck0) begin
    if (cs0 === 1'b0 && prevCs0 !== 1'b0) begin
      rise0 = 0; log0 = '0; miso0 = modelBit(resp0, 0);
    end else if (cs0 === 1'b0 && sck0 === 1'b1 && prevSck0 !== 1'b1) begin
      log0 = {log0[62:0], mosi0}; rise0 = rise0 + 1;
    end else if (cs0 === 1'b0 && sck0 === 1'b0 && prevSck0 === 1'b1) begin
      miso0 = modelBit(resp0, rise0);
    end
    prevCs0 = cs0; prevSck0 = sck0;
  end

  always @(cs1, sck1) begin
    if (cs1 === 1'b0 && prevCs1 !== 1'b0) begin
      rise1 = 0; log1 = '0; miso1 = modelBit(resp1, 0);
    end else if (cs1 === 1'b0 && sck1 === 1'b1 && prevSck1 !== 1'b1) begin
      log1 = {log1[62:0], mosi1}; rise1 = rise1 + 1;
    end else if (cs1 === 1'b0 && sck1 === 1'b0 && prevSck1 === 1'b1) begin
      miso1 = modelBit(resp1, rise1);
    end
    prevCs1 = cs1; prevSck1 = sck1;
  end

  // Monitor: ack count, chip-select falls and the length of the last high run of cs.
  int ackCnt0 = 0, fallCnt0 = 0, run0 = 0, lastRun0 = 0;
  int ackCnt1 = 0;

  always @(negedge sys_clk) begin
    if (ack0 === 1'b1) ackCnt0++;
    if (cs0 === 1'b1) run0++;
    else begin
      if (run0 > 0) begin fallCnt0++; lastRun0 = run0; end
      run0 = 0;
    end
  end

  always @(negedge sys_clk) if (ack1 === 1'b1) ackCnt1++;

  function automatic logic csOf(input int u);    return (u == 0) ? cs0 : cs1;     endfunction
  function automatic logic sckOf(input int u);   return (u == 0) ? sck0 : sck1;   endfunction
  function automatic logic mosiOf(input int u);  return (u == 0) ? mosi0 : mosi1; endfunction
  function automatic logic ackOf(input int u);   return (u == 0) ? ack0 : ack1;   endfunction
  function automatic logic [31:0] dataOf(input int u); return (u == 0) ? data0 : data1; endfunction
  function automatic logic [63:0] logOf(input int u);  return (u == 0) ? log0 : log1;   endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCnt++;
    if (observed !== expected) begin
      failCnt++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Called just after the edge on which cs_n was seen falling (cycle t+1).
  task automatic finishRead(input int u, input logic [31:0] expData, input logic [63:0] expMosi,
                            input int expLat, input string tag);
    int  n;
    bit  done;
    checkOutput({tag, "_sck_start"}, sckOf(u), 1'b0);
    checkOutput({tag, "_mosi_start"}, mosiOf(u), 1'b0);
    n = 0; done = 0;
    while (!done && n < 2000) begin
      @(posedge sys_clk); #1;
      n++;
      if (ackOf(u) === 1'b1) done = 1;
    end
    if (!done) begin
      checkOutput({tag, "_ack_timeout"}, 0, 1);
      return;
    end
    checkOutput({tag, "_latency"}, n + 1, expLat);
    checkOutput({tag, "_data"}, dataOf(u), expData);
    checkOutput({tag, "_cs_at_ack"}, csOf(u), 1'b1);
    checkOutput({tag, "_mosi_bits"}, logOf(u), expMosi);
    @(posedge sys_clk); #1;
    checkOutput({tag, "_ack_pulse"}, ackOf(u), 1'b0);
    checkOutput({tag, "_data_hold"}, dataOf(u), expData);
  endtask

  task automatic applyStimulus(input int u, input logic [31:0] a, input logic [31:0] resp,
                               input logic [31:0] expData, input logic [63:0] expMosi,
                               input int expLat, input string tag);
    int n;
    bit found;
    @(negedge sys_clk);
    addr = a;
    if (u == 0) begin resp0 = resp; cyc0 = 1'b1; end
    else        begin resp1 = resp; cyc1 = 1'b1; end
    n = 0; found = 0;
    while (!found && n < 200) begin
      @(posedge sys_clk); #1;
      n++;
      if (csOf(u) === 1'b0) found = 1;
    end
    if (!found) begin
      checkOutput({tag, "_start_timeout"}, 0, 1);
      return;
    end
    finishRead(u, expData, expMosi, expLat, tag);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fb, ab, n, minRun;
    bit hit;
    logic [7:0] b0, b1, b2, b3;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_cs", cs0, 1'b1);
    checkOutput("rst_sck", sck0, 1'b0);
    checkOutput("rst_mosi", mosi0, 1'b0);
    checkOutput("rst_ack", ack0, 1'b0);
    checkOutput("rst_data", data0, 32'h0);
    checkOutput("rst_cs1", cs1, 1'b1);
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;

    // Basic read, then hold the request high across the ack.
    applyStimulus(0, 32'h0000_C004, 32'h1122_3344, 32'h4433_2211, 64'h0300_C004_0000_0000, 257, "rd_c004");
    fb = fallCnt0;
    repeat (20) @(posedge sys_clk);
    #1;
    checkOutput("held_no_reread", fallCnt0, fb);
    checkOutput("held_cs_high", cs0, 1'b1);
    checkOutput("held_ack_count", ackCnt0, 1);

    @(negedge sys_clk) cyc0 = 1'b0;
    applyStimulus(0, 32'h0000_1234, 32'hA1B2_C3D4, 32'hD4C3_B2A1, 64'h0300_1234_0000_0000, 257, "rd_1234");
    @(negedge sys_clk) cyc0 = 1'b0;
    applyStimulus(0, 32'h0000_0008, 32'h0102_0304, 32'h0403_0201, 64'h0300_0008_0000_0000, 257, "rd_quick");
    checkOutput("gap_after_ack", lastRun0 >= 4, 1'b1);

    // Reset pulse at SCK rising edge 30 with the request held high through release.
    @(negedge sys_clk) cyc0 = 1'b0;
    @(negedge sys_clk);
    addr = 32'h0000_0100; resp0 = 32'h5566_7788; cyc0 = 1'b1;
    n = 0; hit = 0;
    while (!hit && n < 400) begin
      @(posedge sys_clk); #1;
      n++;
      if (rise0 == 30 && cs0 === 1'b0) hit = 1;
    end
    checkOutput("abort_reach_edge30", hit, 1'b1);
    ab = ackCnt0;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_cs_high", cs0, 1'b1);
    checkOutput("abort_sck_low", sck0, 1'b0);
    addr = 32'h0000_0200; resp0 = 32'h99AA_BBCC;
    @(negedge sys_clk) rst_n = 1'b1;
    @(posedge sys_clk); #1;
    checkOutput("rearm_first_edge", cs0, 1'b0);
    finishRead(0, 32'hCCBB_AA99, 64'h0300_0200_0000_0000, 257, "rd_after_rst");
    checkOutput("abort_no_ack", ackCnt0, ab + 1);

    // CLK_DIV=1 instance with high address bits and low bits set.
    @(negedge sys_clk) cyc0 = 1'b0;
    applyStimulus(1, 32'hFF00_3FFF, 32'hDEAD_BEEF, 32'hEFBE_ADDE, 64'h0300_3FFC_0000_0000, 129, "rd_div1");
    checkOutput("div1_ack_count", ackCnt1, 1);
    @(negedge sys_clk) cyc1 = 1'b0;

    // Boot-loader style: 16 back-to-back word reads from address 0.
    ab = ackCnt0;
    minRun = 1000;
    for (int i = 0; i < 16; i++) begin
      b0 = 8'(i * 16 + 1); b1 = 8'(i * 16 + 2); b2 = 8'(i * 16 + 3); b3 = 8'(i * 16 + 4);
      @(negedge sys_clk) cyc0 = 1'b0;
      applyStimulus(0, 32'(4 * i), {b0, b1, b2, b3}, {b3, b2, b1, b0},
                    {8'h03, 24'(4 * i), 32'h0}, 257, $sformatf("seq%0d", i));
      if (lastRun0 < minRun) minRun = lastRun0;
    end
    checkOutput("seq_ack_count", ackCnt0 - ab, 16);
    checkOutput("seq_min_gap_ok", minRun >= 4, 1'b1);
    @(negedge sys_clk) cyc0 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/flash_spi_reader.md
FLASH_SPI_READER -- requirements
Module: flash_spi_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning SCK half-period in sys_clk cycles (legal range 1..255).
REQ-002 SHALL have parameter CS_GAP, default 4, meaning minimum sys_clk cycles spi_cs_n stays high between transactions (legal range 1..255).
REQ-003 SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port i_flash_cycle, input, 1 bit: read request from the boot loader, held high until o_flash_ack is seen.
REQ-006 SHALL have port i_flash_addr, input, 32 bits: byte address; only bits [23:2] are used.
REQ-007 SHALL have port o_flash_ack, output, 1 bit: one-cycle pulse marking read completion.
REQ-008 SHALL have port o_flash_data, output, 32 bits: read word, valid in the o_flash_ack cycle and held until the next ack.
REQ-009 SHALL have port spi_cs_n, output, 1 bit: flash chip select, active-low.
REQ-010 SHALL have port spi_sck, output, 1 bit: SPI clock, mode 0 (idles low).
REQ-011 SHALL have port spi_mosi, output, 1 bit: serial data to the flash.
REQ-012 SHALL have port spi_miso, input, 1 bit: serial data from the flash.

Function
REQ-013 SHALL implement the states IDLE, SHIFT, ACK and GAP.
REQ-014 SHALL keep an internal armed flag: set whenever i_flash_cycle=0 while in IDLE or GAP; cleared on entry to SHIFT.
REQ-015 SHALL leave IDLE only when i_flash_cycle=1 and armed=1; a request held high across an ack SHALL NOT start a second read.
REQ-016 SHALL, on the start cycle t, latch the 64-bit shift word {8'h03, i_flash_addr[23:2], 2'b00, 32'h0}.
REQ-017 SHALL, from cycle t+1, drive spi_cs_n=0, spi_sck=0 and spi_mosi = shift-word bit 63.
REQ-018 SHALL toggle spi_sck every CLK_DIV cycles in SHIFT, giving exactly 64 rising edges; the first rising edge is at t+1+CLK_DIV.
REQ-019 SHALL sample spi_miso on each SCK rising edge and update spi_mosi on each SCK falling edge, MSB first.
REQ-020 SHALL make spi_mosi a don't-care after bit 32 (the last address bit); it SHALL be driven 0 during the data phase.
REQ-021 SHALL assemble the data little-endian: first received byte into o_flash_data[7:0], second into [15:8], third into [23:16], fourth into [31:24]; bits within each byte are received MSB first.
REQ-022 SHALL, on the 64th falling SCK edge (cycle t+1+128*CLK_DIV), raise spi_cs_n, update o_flash_data and pulse o_flash_ack for exactly one cycle (state ACK).
REQ-023 SHALL go from ACK to GAP, hold spi_cs_n high for at least CS_GAP cycles counted from the ACK cycle, then return to IDLE.
REQ-024 SHALL run a started transaction to completion and ack it even if i_flash_cycle drops mid-transaction.
REQ-025 SHALL ignore i_flash_addr and i_flash_cycle during SHIFT, ACK and GAP, apart from updating the armed flag.
REQ-026 SHALL size the divider and gap counters to 8 bits and the bit counter to 7 bits; the bit counter SHALL NOT wrap within a transaction.
REQ-027 SHALL keep o_flash_ack low and spi_sck low in IDLE and GAP.

Reset
REQ-028 SHALL, while sys_rst_n=0 and independent of the clock, force: state=IDLE, armed=1, spi_cs_n=1, spi_sck=0, spi_mosi=0, o_flash_ack=0, o_flash_data=32'h0, all counters=0.
REQ-029 SHALL abort a transaction in progress when reset asserts: spi_cs_n goes high immediately and no ack is issued after release.
REQ-030 SHALL accept a request held high through reset release on the first clock edge after release (armed=1).

Verification
REQ-031 Bench SHALL cover: CLK_DIV=2, i_flash_addr=32'h0000_c004, flash model returns bytes 11,22,33,44 -> MOSI bits 03 00 C0 04, o_flash_data=32'h4433_2211, ack at t+257.
REQ-032 Bench SHALL cover: i_flash_cycle held high for 20 cycles after ack -> no second spi_cs_n fall; dropping it for 1 cycle and re-raising it -> new read starts no earlier than CS_GAP cycles after ack.
REQ-033 Bench SHALL cover: sys_rst_n pulsed low at SCK edge 30 -> spi_cs_n=1 within the same cycle, no ack, and the next read completes correctly.
REQ-034 Bench SHALL cover: CLK_DIV=1 with i_flash_addr=32'hFF00_3FFF -> address bits sent = 24'h003FFC, ack at t+129.
REQ-035 Bench SHALL cover: the boot-loader-style sequence of 16 consecutive word reads from 32'h0 -> 16 acks, correct data each time, spi_cs_n high for at least CS_GAP cycles between reads.
